vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

Parametrised VGA raster timing generator: one block that produces the horizontal and vertical counters, sync pulses and active-video flag for any resolution and timing set. It also adds a pixel-enable input for pixel rates below the clock rate, configurable sync polarity, line and frame start strobes, and a programmable output delay to align syncs with downstream pixel pipelines. It sits in the pixel-clock domain, after the PLL lock/reset gating and before the pattern or framebuffer read logic.

## Interface
- H_ACTIVE, 1024, visible pixels per line
- H_FP / H_SYNC / H_BP, 24 / 136 / 160, horizontal front porch, sync width and back porch (pixels)
- V_ACTIVE, 768, visible lines per frame
- V_FP / V_SYNC / V_BP, 3 / 6 / 29, vertical porches and sync width (lines)
- HS_POL / VS_POL, 0 / 0, active level of hsync / vsync
- PIPE_DLY, 0, extra pixel periods of delay on syncs, video_on and strobes (0..4)
- X_W / Y_W, 11 / 10, pixel_x / pixel_y widths
- FC_W, 16, frame counter width
- clk  in  1  pixel clock. One clock; reset is synchronous and active-high.
- reset  in  1  synchronous, active-high
- pix_en  in  1  pixel advance qualifier. Tie to 1 when the pixel rate equals the clk rate.
- pixel_x  out  X_W  horizontal count, 0..H_TOTAL-1
- pixel_y  out  Y_W  vertical count, 0..V_TOTAL-1
- hsync, vsync  out  1  sync outputs, polarity set by HS_POL / VS_POL
- video_on  out  1  pixel is inside the active area
- line_start  out  1  one-cycle pulse when h=0
- frame_start  out  1  one-cycle pulse when h=0 and v=0
- frame_cnt  out  FC_W  completed-frame count. Present only with the configuration macro.

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP. V_TOTAL is formed the same way.
- Horizontal and vertical axis FSMs each have the states ACTIVE → FRONT → SYNC → BACK → ACTIVE.
  - Each FSM moves to the next state when its counter reaches that segment's upper boundary.
  - The horizontal FSM advances on pix_en.
  - The vertical FSM advances only when pix_en=1 and h=H_TOTAL-1.
- Wrap-around:
  - h=H_TOTAL-1 with pix_en → h=0, and v increments.
  - v=V_TOTAL-1 at line wrap → v=0.
- When pix_en=0, all counters, FSM states and delay stages hold.
- Decode rules:
  - video_on = (h state ACTIVE) && (v state ACTIVE).
  - hsync = HS_POL while the horizontal state is SYNC, otherwise ~HS_POL.
  - vsync follows the same rule, with whole-line granularity.
- Strobes:
  - line_start = pix_en && h==0.
  - frame_start = pix_en && h==0 && v==0.
- Elaboration `$error` if any of the following holds:
  - any segment is 0;
  - PIPE_DLY > 4;
  - 2^X_W < H_TOTAL or 2^Y_W < V_TOTAL.
- Reset values:
  - pixel_x=0, pixel_y=0, both FSMs in ACTIVE;
  - hsync=~HS_POL, vsync=~VS_POL;
  - video_on, line_start, frame_start = 0; frame_cnt=0.
  - With PIPE_DLY=0, the decoded outputs are forced to these inactive values while reset=1.
- Reset mid-frame: on the next clk edge all state returns to its reset value, with no partial line completion. The first pix_en after release emits frame_start.

## Timing
- pixel_x and pixel_y are the counter registers themselves.
- Decoded outputs (hsync, vsync, video_on, strobes) are combinational from those registers when PIPE_DLY=0.
  - With PIPE_DLY=N they pass through N shift stages clocked on pix_en.
  - The result is a lag of exactly N pixel periods behind pixel_x/pixel_y.
- Delay stages reset to the inactive values.
  - During the first N pixel periods after reset the decoded outputs remain inactive.
  - frame_start therefore appears N pixel periods after the counter reaches (0,0).
- Strobes are high for exactly one clk cycle per pixel period, even when pix_en is duty-cycled.
- Frame period = H_TOTAL*V_TOTAL pixel periods.

## Configuration
- VGA_FRAME_CNT_EN defined:
  - the frame_cnt port and its register exist;
  - frame_cnt increments on the same clk edge where v wraps V_TOTAL-1→0;
  - it wraps from 2^FC_W-1 to 0.
- Undefined: the port, the register and FC_W usage are all absent, and the rest of the behaviour is identical.

## Structure
- vga_pkg holds:
  - the axis_state_t enum (ACTIVE, FRONT, SYNC, BACK);
  - the default 1024x768@60 timing constants (65 MHz, negative syncs).
- Sub-module vga_axis_fsm: generic counter plus FSM with parameters ACTIVE/FP/SYNC/BP.
  - Inputs: an advance input, clk and reset.
  - Outputs: count, state and a wrap pulse.
  - Instantiated twice: the horizontal instance advances on pix_en; the vertical instance advances on the horizontal wrap.

## Test plan
Benches use a small timing set: H 8/2/3/3 (H_TOTAL 16), V 4/1/2/1 (V_TOTAL 8), HS_POL=VS_POL=0.
- Reset: hold reset for 3 cycles with pix_en=1 → pixel_x=0, pixel_y=0, hsync=1, vsync=1, video_on=0, both strobes 0.
- pix_en=1, PIPE_DLY=0 →
  - hsync=0 exactly for h=10..12;
  - vsync=0 for v=5..6;
  - video_on=1 only for h 0..7 and v 0..3;
  - frame_start every 128 cycles.
- pix_en high 1 cycle in 2 → frame_start every 256 cycles, each strobe 1 cycle wide, counters unchanged on pix_en=0 cycles.
- PIPE_DLY=2 → the hsync falling edge occurs when pixel_x=12 (2 pixel periods after h=10), and the video_on rising edge occurs when pixel_x=2.
- Assert reset at h=5, v=2 → next cycle counters are 0 and outputs inactive; after release, frame_start occurs on the first pix_en.
- VGA_FRAME_CNT_EN, FC_W=2 → frame_cnt goes 0→1→2→3→0 on successive v wraps; the port is absent when the macro is undefined.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared types and default 1024x768@60 timing (65 MHz pixel clock, negative syncs)
// for the VGA raster timing generator.
package vga_pkg;

  typedef enum logic [1:0] {ACTIVE, FRONT, SYNC, BACK} axis_state_t;

  // Decoded raster outputs carried together through the output delay line
  typedef struct packed {
    logic hs;
    logic vs;
    logic von;
    logic ls;
    logic fs;
  } dec_t;

  localparam int DEF_H_ACTIVE = 1024;
  localparam int DEF_H_FP     = 24;
  localparam int DEF_H_SYNC   = 136;
  localparam int DEF_H_BP     = 160;
  localparam int DEF_V_ACTIVE = 768;
  localparam int DEF_V_FP     = 3;
  localparam int DEF_V_SYNC   = 6;
  localparam int DEF_V_BP     = 29;
  localparam logic DEF_HS_POL = 1'b0;
  localparam logic DEF_VS_POL = 1'b0;

  function automatic int seg_total(input int act, input int fp, input int sync, input int bp);
    return act + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_axis_fsm.sv
// One raster axis: a counter over ACTIVE+FP+SYNC+BP positions with a segment FSM.
// Advances only on adv; wrap pulses combinationally on the last position when adv=1.
module vga_axis_fsm
  import vga_pkg::axis_state_t;
#(
  parameter int ACTIVE = 8,
  parameter int FP     = 2,
  parameter int SYNC   = 3,
  parameter int BP     = 3,
  parameter int CW     = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          adv,
  output logic [CW-1:0] count,
  output axis_state_t   state,
  output logic          wrap
);

  localparam int TOTAL = ACTIVE + FP + SYNC + BP;
  localparam logic [CW-1:0] END_A = CW'(ACTIVE - 1);
  localparam logic [CW-1:0] END_F = CW'(ACTIVE + FP - 1);
  localparam logic [CW-1:0] END_S = CW'(ACTIVE + FP + SYNC - 1);
  localparam logic [CW-1:0] END_T = CW'(TOTAL - 1);

  assign wrap = adv && (count == END_T);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      state <= vga_pkg::ACTIVE;
    end else if (adv) begin
      count <= (count == END_T) ? '0 : count + 1'b1;
      case (state)
        vga_pkg::ACTIVE: if (count == END_A) state <= vga_pkg::FRONT;
        vga_pkg::FRONT:  if (count == END_F) state <= vga_pkg::SYNC;
        vga_pkg::SYNC:   if (count == END_S) state <= vga_pkg::BACK;
        vga_pkg::BACK:   if (count == END_T) state <= vga_pkg::ACTIVE;
        default:         state <= vga_pkg::ACTIVE;
      endcase
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: counters, syncs, video_on, line/frame strobes with
// optional output delay. Define VGA_FRAME_CNT_EN to add the completed-frame counter.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int   H_ACTIVE = DEF_H_ACTIVE,
  parameter int   H_FP     = DEF_H_FP,
  parameter int   H_SYNC   = DEF_H_SYNC,
  parameter int   H_BP     = DEF_H_BP,
  parameter int   V_ACTIVE = DEF_V_ACTIVE,
  parameter int   V_FP     = DEF_V_FP,
  parameter int   V_SYNC   = DEF_V_SYNC,
  parameter int   V_BP     = DEF_V_BP,
  parameter logic HS_POL   = DEF_HS_POL,
  parameter logic VS_POL   = DEF_VS_POL,
  parameter int   PIPE_DLY = 0,
  parameter int   X_W      = 11,
  parameter int   Y_W      = 10
`ifdef VGA_FRAME_CNT_EN
  ,
  parameter int   FC_W     = 16
`endif
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           pix_en,
  output logic [X_W-1:0] pixel_x,
  output logic [Y_W-1:0] pixel_y,
  output logic           hsync,
  output logic           vsync,
  output logic           video_on,
  output logic           line_start,
  output logic           frame_start
`ifdef VGA_FRAME_CNT_EN
  ,
  output logic [FC_W-1:0] frame_cnt
`endif
);

  localparam int H_TOTAL = seg_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = seg_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam dec_t DEC_IDLE = '{hs: ~HS_POL, vs: ~VS_POL, von: 1'b0, ls: 1'b0, fs: 1'b0};

  if (H_ACTIVE <= 0 || H_FP <= 0 || H_SYNC <= 0 || H_BP <= 0 ||
      V_ACTIVE <= 0 || V_FP <= 0 || V_SYNC <= 0 || V_BP <= 0) begin : g_err_seg
    $error("vga_timing_gen: every timing segment must be non-zero");
  end
  if (PIPE_DLY < 0 || PIPE_DLY > 4) begin : g_err_dly
    $error("vga_timing_gen: PIPE_DLY must be 0..4");
  end
  if (H_TOTAL > (1 << X_W) || V_TOTAL > (1 << Y_W)) begin : g_err_w
    $error("vga_timing_gen: X_W/Y_W too narrow for the line/frame totals");
  end

  axis_state_t h_state, v_state;
  logic        h_wrap, v_wrap;

  vga_axis_fsm #(.ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .CW(X_W)) u_h (
    .clk(clk), .reset(reset), .adv(pix_en),
    .count(pixel_x), .state(h_state), .wrap(h_wrap)
  );

  vga_axis_fsm #(.ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .CW(Y_W)) u_v (
    .clk(clk), .reset(reset), .adv(h_wrap),
    .count(pixel_y), .state(v_state), .wrap(v_wrap)
  );

  // Strobes are stored as levels and re-qualified by pix_en at the output so they
  // stay one clk wide whatever the pix_en duty cycle.
  dec_t dec_c, dec_out;
  logic strobe_en;

  always_comb begin
    dec_c     = DEC_IDLE;
    dec_c.hs  = (h_state == SYNC) ? HS_POL : ~HS_POL;
    dec_c.vs  = (v_state == SYNC) ? VS_POL : ~VS_POL;
    dec_c.von = (h_state == ACTIVE) && (v_state == ACTIVE);
    dec_c.ls  = (pixel_x == '0);
    dec_c.fs  = (pixel_x == '0) && (pixel_y == '0);
  end

  if (PIPE_DLY == 0) begin : g_nodly
    assign dec_out = dec_c;
  end else begin : g_dly
    dec_t dec_p [PIPE_DLY];

    always_ff @(posedge clk) begin
      if (reset) begin
        for (int i = 0; i < PIPE_DLY; i++) dec_p[i] <= DEC_IDLE;
      end else if (pix_en) begin
        dec_p[0] <= dec_c;
        for (int i = 1; i < PIPE_DLY; i++) dec_p[i] <= dec_p[i-1];
      end
    end

    assign dec_out = dec_p[PIPE_DLY-1];
  end

  assign strobe_en   = pix_en && !reset;
  assign hsync       = reset ? ~HS_POL : dec_out.hs;
  assign vsync       = reset ? ~VS_POL : dec_out.vs;
  assign video_on    = !reset && dec_out.von;
  assign line_start  = strobe_en && dec_out.ls;
  assign frame_start = strobe_en && dec_out.fs;

`ifdef VGA_FRAME_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) frame_cnt <= '0;
    else if (v_wrap) frame_cnt <= frame_cnt + 1'b1;
  end
`else
  logic unused_v_wrap;
  assign unused_v_wrap = v_wrap;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomized self-checking bench for vga_timing_gen with the small 16x8 timing set,
// comparing a PIPE_DLY=0 and a PIPE_DLY=2 instance against a pixel-count model.
module tb_vga_timing_gen;

  localparam int HA = 8, HF = 2, HS = 3, HB = 3;
  localparam int VA = 4, VF = 1, VS = 2, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;

  logic clk = 1'b0;
  logic reset, pix_en;
  logic [3:0] px0, px2;
  logic [2:0] py0, py2;
  logic hs0, vs0, von0, ls0, fs0;
  logic hs2, vs2, von2, ls2, fs2;
`ifdef VGA_FRAME_CNT_EN
  logic [1:0] fc0, fc2;
`endif

  always #5 clk = ~clk;

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HS_POL(1'b0), .VS_POL(1'b0), .PIPE_DLY(0), .X_W(4), .Y_W(3)
`ifdef VGA_FRAME_CNT_EN
    , .FC_W(2)
`endif
  ) dut0 (
    .clk(clk), .reset(reset), .pix_en(pix_en),
    .pixel_x(px0), .pixel_y(py0), .hsync(hs0), .vsync(vs0), .video_on(von0),
    .line_start(ls0), .frame_start(fs0)
`ifdef VGA_FRAME_CNT_EN
    , .frame_cnt(fc0)
`endif
  );

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HS_POL(1'b0), .VS_POL(1'b0), .PIPE_DLY(2), .X_W(4), .Y_W(3)
`ifdef VGA_FRAME_CNT_EN
    , .FC_W(2)
`endif
  ) dut2 (
    .clk(clk), .reset(reset), .pix_en(pix_en),
    .pixel_x(px2), .pixel_y(py2), .hsync(hs2), .vsync(vs2), .video_on(von2),
    .line_start(ls2), .frame_start(fs2)
`ifdef VGA_FRAME_CNT_EN
    , .frame_cnt(fc2)
`endif
  );

  int tests = 0, errors = 0;
  int pc = 0;
  int cyc = 0;
  int phase = 0;
  int last_fs = -1;
  logic chk_en = 1'b0;
  logic hs2_q = 1'b1, von2_q = 1'b0;

  // Pixel periods elapsed since reset; everything else is derived from it
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset) pc <= 0;
    else if (pix_en) pc <= pc + 1;
  end

  task automatic lit(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, got, exp);
    end
  endtask

  task automatic check_dut(input int dly, input logic [3:0] px, input logic [2:0] py,
                           input logic hs, input logic vs, input logic von,
                           input logic ls, input logic fs);
    int q, h, v;
    logic e_hs, e_vs, e_von, e_ls, e_fs;
    logic [3:0] e_px;
    logic [2:0] e_py;
    e_px = 4'(pc % HT);
    e_py = 3'((pc / HT) % VT);
    e_hs = 1'b1; e_vs = 1'b1; e_von = 1'b0; e_ls = 1'b0; e_fs = 1'b0;
    q = pc - dly;
    if (!reset && q >= 0) begin
      h = q % HT;
      v = (q / HT) % VT;
      e_hs  = !(h >= HA + HF && h < HA + HF + HS);
      e_vs  = !(v >= VA + VF && v < VA + VF + VS);
      e_von = (h < HA) && (v < VA);
      e_ls  = pix_en && (h == 0);
      e_fs  = pix_en && (h == 0) && (v == 0);
    end
    tests++;
    if (px !== e_px || py !== e_py || hs !== e_hs || vs !== e_vs ||
        von !== e_von || ls !== e_ls || fs !== e_fs) begin
      errors++;
      $display("FAIL model_dly%0d cyc=%0d got px=%0d py=%0d hs=%b vs=%b von=%b ls=%b fs=%b expected px=%0d py=%0d hs=%b vs=%b von=%b ls=%b fs=%b",
               dly, cyc, px, py, hs, vs, von, ls, fs, e_px, e_py, e_hs, e_vs, e_von, e_ls, e_fs);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check_dut(0, px0, py0, hs0, vs0, von0, ls0, fs0);
      check_dut(2, px2, py2, hs2, vs2, von2, ls2, fs2);
`ifdef VGA_FRAME_CNT_EN
      lit("frame_cnt_dly0", {30'd0, fc0}, 32'((pc / (HT * VT)) % 4));
      lit("frame_cnt_dly2", {30'd0, fc2}, 32'((pc / (HT * VT)) % 4));
`endif
      if (fs0 && (phase == 2 || phase == 3)) begin
        if (last_fs >= 0)
          lit(phase == 2 ? "fs_period_full" : "fs_period_half", cyc - last_fs,
              phase == 2 ? 128 : 256);
        last_fs = cyc;
      end
      if (phase == 2 && hs2_q && !hs2) lit("dly2_hs_fall_px", {28'd0, px2}, 12);
      if (phase == 2 && !von2_q && von2) lit("dly2_von_rise_px", {28'd0, px2}, 2);
      hs2_q = hs2;
      von2_q = von2;
    end
  end

  initial begin
    logic found;
    reset  = 1'b1;
    pix_en = 1'b1;
    @(posedge clk); #1;
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    lit("rst_px", {28'd0, px0}, 0);
    lit("rst_py", {29'd0, py0}, 0);
    lit("rst_hsync", {31'd0, hs0}, 1);
    lit("rst_vsync", {31'd0, vs0}, 1);
    lit("rst_video_on", {31'd0, von0}, 0);
    lit("rst_line_start", {31'd0, ls0}, 0);
    lit("rst_frame_start", {31'd0, fs0}, 0);
    lit("rst_dly2_hsync", {31'd0, hs2}, 1);
    reset = 1'b0;

    phase = 2; last_fs = -1;
    repeat (390) @(posedge clk);
    #1;

    phase = 3; last_fs = -1;
    repeat (800) begin
      @(posedge clk); #1;
      pix_en = ~pix_en;
    end

    phase = 4;
    repeat (600) begin
      @(posedge clk); #1;
      pix_en = ($urandom_range(0, 3) != 0);
    end

    phase = 5;
    pix_en = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(posedge clk); #1;
      if (px0 == 4'd5 && py0 == 3'd2) found = 1'b1;
    end
    lit("midreset_reach_5_2", {31'd0, found}, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    lit("midreset_px", {28'd0, px0}, 0);
    lit("midreset_py", {29'd0, py0}, 0);
    lit("midreset_video_on", {31'd0, von0}, 0);
    lit("midreset_hsync", {31'd0, hs0}, 1);
    reset = 1'b0;
    pix_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    pix_en = 1'b1;
    #1;
    lit("midreset_first_fs", {31'd0, fs0}, 1);

    phase = 6;
    repeat (400) begin
      @(posedge clk); #1;
      pix_en = $urandom_range(0, 1) != 0;
    end

    @(posedge clk); #1;
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
